// File: rtl/if_id_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID hazard sequencer: state encoding,
// register-specifier width and the hard-wired zero register.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  // Register 0 is hard-wired to zero, so a load targeting it never creates a hazard.
  localparam logic [REG_W-1:0] ZERO_REG = {REG_W{1'b0}};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/if_id_hazard_ctrl_if.sv
// Hazard inputs and pipeline-control outputs between the ID stage and the
// PC, IF/ID and ID/EX registers.
interface if_id_hazard_ctrl_if #(
  parameter int REG_W = pipe_ctrl_pkg::REG_W
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             redirect;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, redirect, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, redirect, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze
  );
endinterface

// File: rtl/if_id_hazard_ctrl_sat_counter.sv
// W-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  // Count one event per cycle until the maximum is reached, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID hazard sequencer: drives PC/IF-ID enables, IF/ID flush, ID/EX bubble
// and back-end freeze from load-use hazards, redirects and memory stalls.
// Control outputs are a combinational decode of state and current inputs.
module if_id_hazard_ctrl #(
  parameter int REG_W        = pipe_ctrl_pkg::REG_W,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  if_id_hazard_ctrl_if.slave    hz,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  import pipe_ctrl_pkg::*;

  localparam logic [REG_W-1:0] ZERO_R  = REG_W'(ZERO_REG);
  localparam logic [2:0]       FC_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state_r;
  state_t     eval_state_s;
  state_t     next_state_s;
  logic [2:0] fc_r;
  logic [2:0] fc_next_s;
  logic       load_use_s;
  logic       stall_inc_s;
  logic       flush_inc_s;
  logic       pc_write_s;
  logic       if_id_write_s;
  logic       if_id_flush_s;
  logic       id_ex_bubble_s;
  logic       pipe_freeze_s;

  // A load in EX whose destination is read by the ID instruction.
  always_comb begin
    load_use_s = hz.ex_mem_read && (hz.ex_rt != ZERO_R) &&
                 ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
  end

  // Leaving MEM_WAIT behaves as the resumed state within the same cycle.
  always_comb begin
    eval_state_s = state_r;
    if (state_r == MEM_WAIT) begin
      eval_state_s = (fc_r != 3'd0) ? FLUSH : RUN;
    end else begin
      eval_state_s = state_r;
    end
  end

  // Priority decode: memory stall, then redirect/flush, then load-use, then run.
  always_comb begin
    next_state_s   = eval_state_s;
    fc_next_s      = fc_r;
    stall_inc_s    = 1'b0;
    flush_inc_s    = 1'b0;
    pc_write_s     = 1'b1;
    if_id_write_s  = 1'b1;
    if_id_flush_s  = 1'b0;
    id_ex_bubble_s = 1'b0;
    pipe_freeze_s  = 1'b0;
    if (!rst_n) begin
      next_state_s = RUN;
      fc_next_s    = 3'd0;
    end else if (hz.mem_busy) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      pipe_freeze_s = 1'b1;
      next_state_s  = MEM_WAIT;
      stall_inc_s   = 1'b1;
    end else if (hz.redirect || (eval_state_s == FLUSH)) begin
      if_id_flush_s = 1'b1;
      if (hz.redirect) begin
        fc_next_s   = FC_LOAD;
        flush_inc_s = 1'b1;
      end else begin
        fc_next_s = fc_r - 3'd1;
      end
      next_state_s = (fc_next_s != 3'd0) ? FLUSH : RUN;
    end else if (load_use_s) begin
      pc_write_s     = 1'b0;
      if_id_write_s  = 1'b0;
      id_ex_bubble_s = 1'b1;
      stall_inc_s    = 1'b1;
    end else begin
      next_state_s = RUN;
    end
  end

  // State and flush-cycle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      fc_r    <= 3'd0;
    end else begin
      state_r <= next_state_s;
      fc_r    <= fc_next_s;
    end
  end

  assign hz.pc_write     = pc_write_s;
  assign hz.if_id_write  = if_id_write_s;
  assign hz.if_id_flush  = if_id_flush_s;
  assign hz.id_ex_bubble = id_ex_bubble_s;
  assign hz.pipe_freeze  = pipe_freeze_s;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc_s),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc_s),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Scoreboard bench: two DUTs (FLUSH_CYCLES=2/CNT_W=16 and FLUSH_CYCLES=3/CNT_W=4)
// share stimulus; a behavioural model pushes expectations, a monitor checks them.
module tb_if_id_hazard_ctrl;

  localparam int FC_A = 2;
  localparam int FC_B = 3;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 15;

  logic        clk;
  logic        rst_n;
  logic [15:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;

  if_id_hazard_ctrl_if ifa ();
  if_id_hazard_ctrl_if ifb ();

  if_id_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(FC_A), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .hz(ifa.slave), .stall_cnt(stall_a), .flush_cnt(flush_a)
  );

  if_id_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(FC_B), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .hz(ifb.slave), .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  typedef struct packed {
    logic [4:0]  ctl_a;
    logic [15:0] st_a;
    logic [15:0] fl_a;
    logic [4:0]  ctl_b;
    logic [15:0] st_b;
    logic [15:0] fl_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: remaining forced-flush cycles after the current one, and counters.
  int rem_a = 0, rem_b = 0, sa = 0, fa = 0, sb = 0, fb = 0;

  // Current stimulus
  logic [4:0] c_rs = 5'd0, c_rt = 5'd0, c_ert = 5'd0;
  logic       c_urt = 1'b0, c_mr = 1'b0, c_rd = 1'b0, c_mb = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  // ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
  task automatic model_step(input int fcyc, input int maxv, input logic lu,
                            inout int rem, inout int st, inout int fl,
                            output logic [4:0] ctl);
    if (c_mb) begin
      ctl = 5'b00001;
      st  = sat_inc(st, maxv);
    end else if (c_rd || rem > 0) begin
      ctl = 5'b11100;
      if (c_rd) begin
        rem = fcyc - 1;
        fl  = sat_inc(fl, maxv);
      end else begin
        rem = rem - 1;
      end
    end else if (lu) begin
      ctl = 5'b00010;
      st  = sat_inc(st, maxv);
    end else begin
      ctl = 5'b11000;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    logic lu;
    logic [4:0] ca, cb;
    if (!rst_n) begin
      rem_a = 0; rem_b = 0; sa = 0; fa = 0; sb = 0; fb = 0;
      e = '{ctl_a: 5'b11000, st_a: 16'd0, fl_a: 16'd0,
            ctl_b: 5'b11000, st_b: 16'd0, fl_b: 16'd0};
    end else begin
      lu = c_mr && (c_ert != 5'd0) && ((c_ert == c_rs) || (c_urt && (c_ert == c_rt)));
      e.st_a = 16'(sa); e.fl_a = 16'(fa);
      e.st_b = 16'(sb); e.fl_b = 16'(fb);
      model_step(FC_A, MAX_A, lu, rem_a, sa, fa, ca);
      model_step(FC_B, MAX_B, lu, rem_b, sb, fb, cb);
      e.ctl_a = ca;
      e.ctl_b = cb;
    end
    exp_q.push_back(e);
  endtask

  task automatic apply();
    ifa.id_rs = c_rs; ifa.id_rt = c_rt; ifa.id_uses_rt = c_urt; ifa.ex_mem_read = c_mr;
    ifa.ex_rt = c_ert; ifa.redirect = c_rd; ifa.mem_busy = c_mb;
    ifb.id_rs = c_rs; ifb.id_rt = c_rt; ifb.id_uses_rt = c_urt; ifb.ex_mem_read = c_mr;
    ifb.ex_rt = c_ert; ifb.redirect = c_rd; ifb.mem_busy = c_mb;
  endtask

  task automatic cyc(input logic rst_v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic mr, input logic [4:0] ert,
                     input logic rd, input logic mb);
    @(posedge clk);
    #1;
    rst_n = rst_v;
    c_rs = rs; c_rt = rt; c_urt = urt; c_mr = mr; c_ert = ert; c_rd = rd; c_mb = mb;
    apply();
    push_expect();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a.pc_write",     32'(ifa.pc_write),     32'(e.ctl_a[4]));
        chk("a.if_id_write",  32'(ifa.if_id_write),  32'(e.ctl_a[3]));
        chk("a.if_id_flush",  32'(ifa.if_id_flush),  32'(e.ctl_a[2]));
        chk("a.id_ex_bubble", 32'(ifa.id_ex_bubble), 32'(e.ctl_a[1]));
        chk("a.pipe_freeze",  32'(ifa.pipe_freeze),  32'(e.ctl_a[0]));
        chk("a.stall_cnt",    32'(stall_a),          32'(e.st_a));
        chk("a.flush_cnt",    32'(flush_a),          32'(e.fl_a));
        chk("b.pc_write",     32'(ifb.pc_write),     32'(e.ctl_b[4]));
        chk("b.if_id_write",  32'(ifb.if_id_write),  32'(e.ctl_b[3]));
        chk("b.if_id_flush",  32'(ifb.if_id_flush),  32'(e.ctl_b[2]));
        chk("b.id_ex_bubble", 32'(ifb.id_ex_bubble), 32'(e.ctl_b[1]));
        chk("b.pipe_freeze",  32'(ifb.pipe_freeze),  32'(e.ctl_b[0]));
        chk("b.stall_cnt",    32'(stall_b),          32'(e.st_b));
        chk("b.flush_cnt",    32'(flush_b),          32'(e.fl_b));
      end
    end
  end

  // Stimulus: directed scenarios, a random phase, then an asynchronous reset.
  initial begin
    rst_n = 1'b0;
    apply();
    // Reset held two cycles, then idle
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(3);
    // Load-use via rs, then cleared
    cyc(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    idle(2);
    // Load into r0: never a hazard
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(1);
    // Load-use via rt only when rt is read
    cyc(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    cyc(1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    idle(1);
    // Redirect pulse
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(4);
    // Redirect coincident with load-use: no bubble
    cyc(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    idle(4);
    // Memory stall during the second flush cycle
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(4);
    // Redirect during flush reloads the flush length
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(4);
    // Long memory stall: 4-bit counter saturates
    for (int i = 0; i < 20; i++) cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(2);
    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
          1'($urandom_range(1, 0)), 5'($urandom_range(3, 0)),
          ($urandom_range(9, 0) == 0), ($urandom_range(9, 0) == 0));
    end
    idle(2);
    // Asynchronous reset between edges while waiting on memory
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    c_mb = 1'b1; c_rd = 1'b1;
    apply();
    #2;
    rst_n = 1'b0;
    push_expect();
    cyc(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    idle(3);
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
